// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road traffic-light controller.
//   Counts ticks from the upstream interval timer to time each phase. The
//   phases run MG -> MY -> AR1 -> SG -> SY -> AR2 -> MG. It returns 'run' to
//   the timer enable so that timing stops while 'hold' is asserted.
//   Optional feature macro: TLC_PED_EN. When it is defined, a pedestrian
//   request can end main green early, and 'walk' is lit during side green.
//   Debug outputs state_dbg, cnt_dbg and ped_pend_dbg expose the internal
//   state for checkers.
//
// Tick acceptance: a tick is consumed at a rising clk edge only when
// tick=1 and hold=0. That is the only "transfer" in this block. There is
// no backpressure other than hold, and 'run' (= ~hold) is what tells the
// timer that its ticks are being consumed.
module traffic_light_fsm #(
  parameter int MAIN_GREEN_T = 20,
  parameter int SIDE_GREEN_T = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int MIN_GREEN_T  = 5,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             r,
  input  logic             tick,
  input  logic             hold,
  input  logic             ped_req,
  output logic             run,
  output logic [2:0]       main_lamp,
  output logic [2:0]       side_lamp,
  output logic             walk,
  output logic             phase_done,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] cnt_dbg,
  output logic             ped_pend_dbg
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_SG  = 3'd3,
    S_SY  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  // Last counter value of each phase (phase length minus one).
  localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MAIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN_T - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN_T - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] last;
  logic             accept;
  logic             early_exit;
  logic             phase_end;
  logic             pd_nxt;
  logic             ped_pend;

  assign accept = tick & ~hold;
  assign run    = ~hold;

`ifdef TLC_PED_EN
  logic ped_pend_nxt;
  logic enter_sg;

  // A pending request can end main green once the minimum green has elapsed.
  assign early_exit = (state == S_MG) && ped_pend && (cnt >= MIN_LAST);
  assign enter_sg   = (state == S_AR1) && (state_nxt == S_SG);

  // Pending-request flag: entering side green clears it, and the clear wins
  // over a request that arrives on the same edge.
  always_comb begin
    ped_pend_nxt = ped_pend;
    if (enter_sg) begin
      ped_pend_nxt = 1'b0;
    end else if (ped_req) begin
      ped_pend_nxt = 1'b1;
    end
  end

  // Pending-request register.
  always_ff @(posedge clk) begin
    if (r) begin
      ped_pend <= 1'b0;
    end else begin
      ped_pend <= ped_pend_nxt;
    end
  end

  assign walk = (state == S_SG);
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign early_exit     = 1'b0;
  assign ped_pend       = 1'b0;
  assign walk           = 1'b0;
`endif

  // Next-state and counter logic: advance on an accepted tick at the end of a phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pd_nxt    = 1'b0;
    last      = MG_LAST;
    case (state)
      S_MG:         last = MG_LAST;
      S_MY, S_SY:   last = Y_LAST;
      S_AR1, S_AR2: last = AR_LAST;
      S_SG:         last = SG_LAST;
      default:      last = '0;
    endcase
    phase_end = (cnt == last) || early_exit;
    if (accept) begin
      if (phase_end) begin
        cnt_nxt = '0;
        pd_nxt  = 1'b1;
        case (state)
          S_MG:    state_nxt = S_MY;
          S_MY:    state_nxt = S_AR1;
          S_AR1:   state_nxt = S_SG;
          S_SG:    state_nxt = S_SY;
          S_SY:    state_nxt = S_AR2;
          S_AR2:   state_nxt = S_MG;
          default: state_nxt = S_MG;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State, phase counter and phase_done pulse registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (r) begin
      state      <= S_MG;
      cnt        <= '0;
      phase_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      phase_done <= pd_nxt;
    end
  end

  // Moore lamp decode, {red,yellow,green}; only one road is ever non-red.
  always_comb begin
    main_lamp = 3'b100;
    side_lamp = 3'b100;
    case (state)
      S_MG:    main_lamp = 3'b001;
      S_MY:    main_lamp = 3'b010;
      S_SG:    side_lamp = 3'b001;
      S_SY:    side_lamp = 3'b010;
      default: begin
        main_lamp = 3'b100;
        side_lamp = 3'b100;
      end
    endcase
  end

  assign state_dbg    = state;
  assign cnt_dbg      = cnt;
  assign ped_pend_dbg = ped_pend;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed bench for traffic_light_fsm with default parameters.
// Build with +define+TLC_PED_EN to exercise the pedestrian feature.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic       ped_req = 1'b0;
  logic       run;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;
  logic       phase_done;
  logic [2:0] state_dbg;
  logic [4:0] cnt_dbg;
  logic       ped_pend_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (spec-level phase sequencing, no pedestrian logic).
  int m_state = 0;
  int m_cnt   = 0;
  int m_pd    = 0;

  traffic_light_fsm dut (
    .clk(clk), .r(r), .tick(tick), .hold(hold), .ped_req(ped_req),
    .run(run), .main_lamp(main_lamp), .side_lamp(side_lamp), .walk(walk),
    .phase_done(phase_done), .state_dbg(state_dbg), .cnt_dbg(cnt_dbg),
    .ped_pend_dbg(ped_pend_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic int len_of(input int s);
    case (s)
      0: return 20;
      1: return 3;
      2: return 1;
      3: return 10;
      4: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_main(input int s);
    if (s == 0) return 3'b001;
    if (s == 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int s);
    if (s == 3) return 3'b001;
    if (s == 4) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic exp_walk(input int s);
`ifdef TLC_PED_EN
    return (s == 3);
`else
    return (s < 0);
`endif
  endfunction

  // Driver: apply inputs, clock once, update the model, return at the falling edge.
  task automatic do_cycle(input logic t, input logic h, input logic p, input logic rr);
    tick = t; hold = h; ped_req = p; r = rr;
    @(posedge clk);
    if (rr) begin
      m_state = 0; m_cnt = 0; m_pd = 0;
    end else if (t && !h) begin
      if (m_cnt == len_of(m_state) - 1) begin
        m_state = (m_state + 1) % 6; m_cnt = 0; m_pd = 1;
      end else begin
        m_cnt = m_cnt + 1; m_pd = 0;
      end
    end else begin
      m_pd = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_cycle(0, 0, 0, 1);
    do_cycle(0, 0, 0, 1);
    do_cycle(0, 0, 0, 0);
    n_vec++;
    if (main_lamp !== 3'b001) begin n_err++; $display("FAIL reset_main: got %b need 001", main_lamp); end
    n_vec++;
    if (side_lamp !== 3'b100) begin n_err++; $display("FAIL reset_side: got %b need 100", side_lamp); end
    n_vec++;
    if (walk !== 1'b0) begin n_err++; $display("FAIL reset_walk: got %b need 0", walk); end
    n_vec++;
    if (ped_pend_dbg !== 1'b0) begin n_err++; $display("FAIL reset_ped_pend: got %b need 0", ped_pend_dbg); end
    for (int i = 0; i < 50; i++) begin
      do_cycle(0, 0, 0, 0);
      n_vec++;
      if (state_dbg !== 3'd0 || cnt_dbg !== 5'd0 || phase_done !== 1'b0 || main_lamp !== 3'b001) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got st=%0d cnt=%0d pd=%b main=%b need 0 0 0 001",
                 i, state_dbg, cnt_dbg, phase_done, main_lamp);
      end
    end
  endtask

  task automatic test_full_cycle;
    int pd_cnt;
    pd_cnt = 0;
    do_cycle(0, 0, 0, 1);
    for (int i = 0; i <= 76; i++) begin
      n_vec++;
      if (state_dbg !== 3'(m_state) || cnt_dbg !== 5'(m_cnt) || phase_done !== 1'(m_pd)) begin
        n_err++;
        $display("FAIL cycle_state i=%0d: got st=%0d cnt=%0d pd=%b need st=%0d cnt=%0d pd=%0d",
                 i, state_dbg, cnt_dbg, phase_done, m_state, m_cnt, m_pd);
      end
      n_vec++;
      if (main_lamp !== exp_main(m_state) || side_lamp !== exp_side(m_state) ||
          !$onehot(main_lamp) || !$onehot(side_lamp) || walk !== exp_walk(m_state)) begin
        n_err++;
        $display("FAIL cycle_lamps i=%0d: got main=%b side=%b walk=%b need main=%b side=%b walk=%b",
                 i, main_lamp, side_lamp, walk, exp_main(m_state), exp_side(m_state), exp_walk(m_state));
      end
      if (phase_done === 1'b1) pd_cnt++;
      if (i == 38 || i == 76) begin
        n_vec++;
        if (state_dbg !== 3'd0 || cnt_dbg !== 5'd0 || phase_done !== 1'b1) begin
          n_err++;
          $display("FAIL cycle_wrap i=%0d: got st=%0d cnt=%0d pd=%b need 0 0 1", i, state_dbg, cnt_dbg, phase_done);
        end
      end
      if (i < 76) do_cycle(1, 0, 0, 0);
    end
    n_vec++;
    if (pd_cnt != 12) begin n_err++; $display("FAIL cycle_pd_count: got %0d need 12", pd_cnt); end
  endtask

  task automatic test_hold;
    int c;
    int sg_ticks;
    logic t;
    logic [2:0] st;
    logic [4:0] ct;
    c = 0;
    sg_ticks = 0;
    do_cycle(0, 0, 0, 1);
    while (!(m_state == 3 && m_cnt == 4) && c < 400) begin
      t = (c % 4 == 0);
      if (state_dbg == 3'd3 && t) sg_ticks++;
      do_cycle(t, 0, 0, 0);
      c++;
    end
    n_vec++;
    if (state_dbg !== 3'd3 || cnt_dbg !== 5'd4) begin
      n_err++;
      $display("FAIL hold_reach_sg: got st=%0d cnt=%0d need 3 4", state_dbg, cnt_dbg);
    end
    for (int i = 0; i < 10; i++) begin
      t = (c % 4 == 0);
      st = state_dbg;
      ct = cnt_dbg;
      do_cycle(t, 1, 0, 0);
      c++;
      n_vec++;
      if (run !== 1'b0 || state_dbg !== st || cnt_dbg !== ct || phase_done !== 1'b0) begin
        n_err++;
        $display("FAIL hold_frozen i=%0d: got run=%b st=%0d cnt=%0d pd=%b need run=0 st=%0d cnt=%0d pd=0",
                 i, run, state_dbg, cnt_dbg, phase_done, st, ct);
      end
    end
    do_cycle(0, 0, 0, 0);
    c++;
    n_vec++;
    if (run !== 1'b1) begin n_err++; $display("FAIL hold_run_release: got %b need 1", run); end
    while (m_state == 3 && c < 800) begin
      t = (c % 4 == 0);
      if (state_dbg == 3'd3 && t) sg_ticks++;
      do_cycle(t, 0, 0, 0);
      c++;
      n_vec++;
      if (state_dbg !== 3'(m_state) || cnt_dbg !== 5'(m_cnt)) begin
        n_err++;
        $display("FAIL hold_track: got st=%0d cnt=%0d need %0d %0d", state_dbg, cnt_dbg, m_state, m_cnt);
      end
    end
    n_vec++;
    if (sg_ticks != 10 || state_dbg !== 3'd4) begin
      n_err++;
      $display("FAIL hold_sg_ticks: got %0d ticks st=%0d need 10 ticks st=4", sg_ticks, state_dbg);
    end
  endtask

  task automatic test_reset_mid;
    do_cycle(0, 0, 0, 1);
    for (int i = 0; i < 35; i++) do_cycle(1, 0, 0, 0);
    n_vec++;
    if (state_dbg !== 3'd4 || cnt_dbg !== 5'd1 || side_lamp !== 3'b010) begin
      n_err++;
      $display("FAIL rstmid_pre: got st=%0d cnt=%0d side=%b need 4 1 010", state_dbg, cnt_dbg, side_lamp);
    end
    do_cycle(1, 0, 0, 1);
    n_vec++;
    if (state_dbg !== 3'd0 || cnt_dbg !== 5'd0 || main_lamp !== 3'b001 ||
        side_lamp !== 3'b100 || phase_done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_post: got st=%0d cnt=%0d main=%b side=%b pd=%b need 0 0 001 100 0",
               state_dbg, cnt_dbg, main_lamp, side_lamp, phase_done);
    end
  endtask

`ifdef TLC_PED_EN
  task automatic test_ped;
    int walk_ticks;
    int guard;
    walk_ticks = 0;
    guard = 0;
    do_cycle(0, 0, 0, 1);
    do_cycle(1, 0, 0, 0);
    do_cycle(1, 0, 1, 0);
    n_vec++;
    if (ped_pend_dbg !== 1'b1 || cnt_dbg !== 5'd2) begin
      n_err++;
      $display("FAIL ped_latch: got pend=%b cnt=%0d need 1 2", ped_pend_dbg, cnt_dbg);
    end
    do_cycle(1, 0, 0, 0);
    do_cycle(1, 0, 0, 0);
    n_vec++;
    if (state_dbg !== 3'd0 || cnt_dbg !== 5'd4) begin
      n_err++;
      $display("FAIL ped_before_cut: got st=%0d cnt=%0d need 0 4", state_dbg, cnt_dbg);
    end
    do_cycle(1, 0, 0, 0);
    n_vec++;
    if (state_dbg !== 3'd1 || cnt_dbg !== 5'd0 || phase_done !== 1'b1 || main_lamp !== 3'b010) begin
      n_err++;
      $display("FAIL ped_cut: got st=%0d cnt=%0d pd=%b main=%b need 1 0 1 010",
               state_dbg, cnt_dbg, phase_done, main_lamp);
    end
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0);
    do_cycle(1, 0, 1, 0);
    n_vec++;
    if (state_dbg !== 3'd3 || ped_pend_dbg !== 1'b0 || walk !== 1'b1) begin
      n_err++;
      $display("FAIL ped_enter_sg: got st=%0d pend=%b walk=%b need 3 0 1", state_dbg, ped_pend_dbg, walk);
    end
    while (walk === 1'b1 && guard < 40) begin
      walk_ticks++;
      do_cycle(1, 0, 0, 0);
      guard++;
    end
    n_vec++;
    if (walk_ticks != 10 || state_dbg !== 3'd4 || ped_pend_dbg !== 1'b0) begin
      n_err++;
      $display("FAIL ped_walk: got ticks=%0d st=%0d pend=%b need 10 4 0", walk_ticks, state_dbg, ped_pend_dbg);
    end
  endtask
`else
  task automatic test_no_ped;
    do_cycle(0, 0, 1, 1);
    for (int i = 0; i < 19; i++) begin
      do_cycle(1, 0, 1, 0);
      n_vec++;
      if (walk !== 1'b0 || state_dbg !== 3'd0) begin
        n_err++;
        $display("FAIL noped_mg i=%0d: got walk=%b st=%0d need 0 0", i, walk, state_dbg);
      end
    end
    n_vec++;
    if (cnt_dbg !== 5'd19) begin n_err++; $display("FAIL noped_cnt: got %0d need 19", cnt_dbg); end
    do_cycle(1, 0, 1, 0);
    n_vec++;
    if (state_dbg !== 3'd1 || walk !== 1'b0 || ped_pend_dbg !== 1'b0) begin
      n_err++;
      $display("FAIL noped_my: got st=%0d walk=%b pend=%b need 1 0 0", state_dbg, walk, ped_pend_dbg);
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_full_cycle;
    test_hold;
    test_reset_mid;
`ifdef TLC_PED_EN
    test_ped;
`else
    test_no_ped;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
